// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
// Optional checksum trailer and CHK state: define IMEM_LOADER_CHECKSUM_EN

module imem_loader #(
  parameter int COL = 32,
  parameter int ROW = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  output logic           in_ready,
  output logic           we,
  output logic [31:0]    waddr,
  output logic [COL-1:0] wdata,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           core_rst_n
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     bcnt_q, bcnt_d;     // byte position within the current 4-byte group
  logic [8:0]     word_q, word_d;     // index of the word being assembled
  logic [8:0]     cnt_q, cnt_d;       // word count from the header (already bounded by ROW)
  logic [23:0]    sh_q, sh_d;         // the up-to-three earlier bytes of the current group
  logic [7:0]     csum_q, csum_d;     // running XOR of header and payload bytes
  logic           we_q, we_d;
  logic [31:0]    waddr_q, waddr_d;
  logic [COL-1:0] wdata_q, wdata_d;

  logic           accept;
  logic [31:0]    assembled;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and datapath update: byte acceptance, word assembly, write issue
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    csum_d    = csum_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    accept    = in_valid && in_ready;
    // Little-endian: the newest byte lands in the top lane once four are in
    assembled = {in_data, sh_q};

    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        word_d = '0;
        sh_d   = '0;
        csum_d = '0;
        if (start) state_d = S_HDR;
      end

      S_HDR: begin
        if (accept) begin
          sh_d   = assembled[31:8];
          csum_d = csum_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (assembled > 32'(ROW)) begin
              state_d = S_ERR;
            end else if (assembled == 32'd0) begin
              if (CSUM_EN) state_d = S_CHK;
              else         state_d = S_DONE;
            end else begin
              cnt_d   = assembled[8:0];
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          sh_d   = assembled[31:8];
          csum_d = csum_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = COL'(assembled);
            waddr_d = {21'd0, word_q, 2'b00};
            word_d  = word_q + 9'd1;
            // The header bound keeps word_q below ROW, so waddr never wraps
            if (word_q + 9'd1 == cnt_q) begin
              if (CSUM_EN) state_d = S_CHK;
              else         state_d = S_DONE;
            end
          end
        end
      end

      S_CHK: begin
        if (accept) begin
          if (in_data == csum_q) state_d = S_DONE;
          else                   state_d = S_ERR;
        end
      end

      S_DONE, S_ERR: begin
        if (start) begin
          bcnt_d  = '0;
          word_d  = '0;
          sh_d    = '0;
          csum_d  = '0;
          state_d = S_HDR;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, write port straight from its registers
  always_comb begin
    busy       = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
    in_ready   = busy;
    done       = (state_q == S_DONE);
    err        = (state_q == S_ERR);
    core_rst_n = (state_q == S_DONE);
    we         = we_q;
    waddr      = waddr_q;
    wdata      = wdata_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
// Expectations follow IMEM_LOADER_CHECKSUM_EN the same way the design does

module tb_imem_loader;

  localparam int ROW = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        core_rst_n;

  imem_loader #(.COL(32), .ROW(ROW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .core_rst_n (core_rst_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [63:0] wr_q[$];
  int          wr_cyc[$];
  logic [31:0] wq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe with its cycle number
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_q.push_back({waddr, wdata});
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer bytes with a gap pattern: 0 full rate, 1 valid toggling, 2 random gaps
  task automatic send(input logic [7:0] b[$], input int mode, output int drops);
    int i = 0;
    int guard = 0;
    bit v;
    bit x;
    bit tog = 1'b1;
    drops = 0;
    while (i < b.size() && guard < 5000) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data  = v ? b[i] : 8'($urandom);
      if (in_ready !== 1'b1) drops++;
      x = v && (in_ready === 1'b1);
      tick();
      if (x) i++;
      guard++;
    end
    in_valid = 1'b0;
    check("send_complete", 64'(guard < 5000), 64'd1);
  endtask

  // One complete load, judged against a model built from the stream rules
  task automatic run_load(input string name, input logic [31:0] count,
                          input logic [31:0] words[$], input logic [7:0] flip,
                          input int mode);
    logic [7:0]  bq[$];
    logic [63:0] exp_w[$];
    logic [7:0]  cs;
    bit          ok_hdr;
    bit          exp_done;
    int          drops;
    int          c0;
    ok_hdr = (count <= 32'(ROW));
    for (int k = 0; k < 4; k++) bq.push_back(count[8*k +: 8]);
    if (ok_hdr) begin
      for (int i = 0; i < int'(count); i++) begin
        for (int k = 0; k < 4; k++) bq.push_back(words[i][8*k +: 8]);
        exp_w.push_back({32'(i * 4), words[i]});
      end
    end
    cs = 8'h00;
    foreach (bq[i]) cs ^= bq[i];
    exp_done = ok_hdr;
    if (CSUM && ok_hdr) begin
      bq.push_back(cs ^ flip);
      exp_done = (flip == 8'h00);
    end

    wr_q.delete();
    wr_cyc.delete();
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    check({name, "_busy_after_start"}, 64'(busy), 64'd1);

    send(bq, mode, drops);
    check({name, "_ready_held"}, 64'(drops), 64'd0);
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_err"}, 64'(err), 64'(!exp_done));
    if (!CSUM && ok_hdr && count != 0) check({name, "_final_we"}, 64'(we), 64'd1);

    tick();
    tick();
    check({name, "_in_ready_idle"}, 64'(in_ready), 64'd0);
    check({name, "_busy_end"}, 64'(busy), 64'd0);
    check({name, "_core_rst_n"}, 64'(core_rst_n), 64'(exp_done));
    check({name, "_n_writes"}, 64'(wr_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      if (i < wr_q.size()) begin
        check({name, "_write"}, wr_q[i], exp_w[i]);
        if (mode == 0) check({name, "_we_cycle"}, 64'(wr_cyc[i] - c0), 64'(9 + 4 * i));
      end
    end
  endtask

  initial begin
    logic [7:0] rb[$];
    int         drops;
    int         n;

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_flags", 64'({busy, done, err, core_rst_n}), 64'd0);
    rst_n = 1'b1;
    tick();

    wq.delete();
    wq.push_back(32'h00100513);
    wq.push_back(32'h00200593);
    run_load("plan_full", 32'd2, wq, 8'h00, 0);
    run_load("plan_toggle", 32'd2, wq, 8'h00, 1);

    wq.delete();
    run_load("hdr_257", 32'd257, wq, 8'h00, 0);
    run_load("zero_ok", 32'd0, wq, 8'h00, 0);
    if (CSUM) run_load("zero_bad", 32'd0, wq, 8'h01, 0);

    if (CSUM) begin
      wq.push_back(32'h0000006F);
      run_load("one_ok", 32'd1, wq, 8'h00, 0);
      run_load("one_bad", 32'd1, wq, 8'h01, 0);
    end

    // Largest legal image fills the whole memory
    wq.delete();
    for (int i = 0; i < ROW; i++) wq.push_back($urandom);
    run_load("full_row", 32'(ROW), wq, 8'h00, 2);

    for (int t = 0; t < 8; t++) begin
      wq.delete();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      run_load("rand", 32'(n), wq, CSUM && ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
               $urandom_range(0, 2));
    end
    wq.delete();
    run_load("rand_oversize", 32'($urandom_range(ROW + 1, 100000)), wq, 8'h00, 2);

    // Reset after 6 of 8 payload bytes: only word 0 may have been written
    wr_q.delete();
    wr_cyc.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    rb.delete();
    rb.push_back(8'h02); rb.push_back(8'h00); rb.push_back(8'h00); rb.push_back(8'h00);
    rb.push_back(8'h11); rb.push_back(8'h22); rb.push_back(8'h33); rb.push_back(8'h44);
    rb.push_back(8'h55); rb.push_back(8'h66);
    send(rb, 0, drops);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", 64'({in_ready, we, busy, done, err, core_rst_n}), 64'd0);
    check("midrst_waddr_wdata", {waddr, wdata}, 64'd0);
    repeat (4) tick();
    check("midrst_writes", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() > 0) check("midrst_word0", wr_q[0], {32'h0, 32'h44332211});
    rst_n = 1'b1;
    tick();
    wq.delete();
    wq.push_back(32'hDEADBEEF);
    wq.push_back(32'h0BADF00D);
    run_load("after_rst", 32'd2, wq, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory read by the fetch stage. It accepts a little-endian byte stream over a valid/ready handshake. The stream is a 32-bit word-count header followed by that many instruction words. It assembles each group of four bytes into a 32-bit instruction and issues single-cycle write strobes to the writable instruction-memory port. The core is held in reset until the load completes successfully.

## Interface
- COL, 32, instruction word width in bits; only 32 is supported.
- ROW, 256, instruction memory depth in words; this is the maximum accepted word count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that arms a new load; honoured only in IDLE, DONE or ERR
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready
- we  output  1  instruction-memory write strobe, one cycle per word
- waddr  output  32  byte address of the write, always word aligned (waddr[1:0]=0)
- wdata  output  COL  instruction word to write
- busy  output  1  high in HDR, DATA and CHK
- done  output  1  high in DONE
- err  output  1  high in ERR
- core_rst_n  output  1  core reset, active low; high only in DONE

## Operation
- States: IDLE, HDR, DATA, CHK, DONE, ERR. Reset enters IDLE.
- IDLE:
  - start → HDR.
  - Clear byte counter, word counter, shift register and checksum.
- HDR:
  - Accept 4 bytes; byte k goes to count[8k+7:8k].
  - After the 4th byte:
    - count > ROW → ERR.
    - count == 0 → CHK if the checksum is compiled in, else DONE.
    - Otherwise → DATA.
- DATA:
  - Accept bytes; byte k of a word goes to wdata[8k+7:8k].
  - On the 4th byte of word i: register wdata, set waddr = i<<2, and pulse we for one cycle.
  - After word count−1 → CHK, or DONE when the checksum is not compiled in.
- CHK:
  - Accept 1 byte. If it equals the running checksum → DONE, else → ERR.
- DONE: in_ready=0 and core_rst_n=1. start → HDR and core_rst_n drops the next cycle.
- ERR: in_ready=0 and core_rst_n=0. Only start (→ HDR) or rst_n exits.
- start while busy is ignored.
- Bytes offered while in_ready=0 are not consumed; the upstream holds them.
- in_valid may drop mid-word. Partial assembly is retained indefinitely with no timeout.
- Word counter is 9 bits wide. waddr never exceeds (ROW−1)<<2 because the header check guarantees it, so there is no wrap-around.

## Timing
- Reset values: state=IDLE, in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, core_rst_n=0.
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- in_ready=1 in every cycle of HDR, DATA and CHK, so there is one byte per cycle at full rate.
- we asserts in the cycle after the 4th byte of a word is accepted, for exactly one cycle, with waddr/wdata valid in that cycle.
- Full-rate load of N words:
  - Header accepted in cycles 1–4 after the start cycle.
  - Word i's we occurs in cycle 5+4i+4.
- Timing of done/err/core_rst_n:
  - done/core_rst_n rise the cycle after the last byte is accepted. That is the same cycle as the final we.
  - err rises the cycle after the offending byte.
- rst_n assertion mid-load:
  - Immediately returns to IDLE and all outputs go to reset values, including we=0 even if a write was pending.
  - A partially written memory is not cleared.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The stream ends with one checksum byte.
  - The checksum is the XOR of all header and payload bytes.
  - The CHK state exists. A mismatch → ERR, with memory contents already written.
- Not defined:
  - No trailing byte and no CHK state.
  - DONE follows the last word (or a zero header) directly. ERR is reachable only by count > ROW.

## Test plan
- Reset then start, stream 02 00 00 00 | 13 05 10 00 | 93 05 20 00 at full rate:
  - Exactly two we pulses: waddr 0x0 wdata 0x00100513, then waddr 0x4 wdata 0x00200593.
  - Then done=1, core_rst_n=1.
- Same stream with in_valid toggled 1-0-1 every cycle: identical writes and data; in_ready stays 1 throughout.
- Header 01 01 00 00 (257 > ROW): err=1 after the 4th byte, no we, in_ready=0, core_rst_n=0. A following start re-enters HDR.
- Header 00 00 00 00:
  - Checksum enabled: CHK byte 00 → done. CHK byte 01 → err.
  - Checksum disabled: done with zero writes.
- Checksum enabled, one-word load 01 00 00 00 | 6F 00 00 00:
  - Trailer 6E → done.
  - Trailer 6F → err, after the we at waddr 0x0 wdata 0x0000006F.
- Assert rst_n low after 6 of 8 payload bytes: all outputs at reset values asynchronously, no further we. After release, start plus a full stream loads correctly.
